// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM state encoding
// and the iterative-op classifier. Optional macro: ALU_DIV_EN (enables DIV/REM).
package alu_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_OR   = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SLT  = 5'b00111;
    localparam logic [4:0] OP_MUL  = 5'b01000;
    localparam logic [4:0] OP_MULH = 5'b01001;
    localparam logic [4:0] OP_DIV  = 5'b01010;
    localparam logic [4:0] OP_REM  = 5'b01011;
    localparam logic [4:0] OP_NOR  = 5'b01100;
    localparam logic [4:0] OP_XOR  = 5'b01101;
    localparam logic [4:0] OP_SRL  = 5'b10000;
    localparam logic [4:0] OP_SRA  = 5'b11000;
    localparam logic [4:0] OP_SLL  = 5'b11001;
    localparam logic [4:0] OP_ANDN = 5'b11111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ITER   = 3'd2,
        ST_FINISH = 3'd3,
        ST_DONE   = 3'd4
    } alu_state_t;

    // True for opcodes that run through the multi-cycle datapath.
    function automatic logic is_iter_op(input logic [4:0] op);
`ifdef ALU_DIV_EN
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
`else
        return (op == OP_MUL) || (op == OP_MULH);
`endif
    endfunction

endpackage

// File: rtl/alu_iter_core.sv
// Iterative datapath: shift-add multiplier and (with ALU_DIV_EN) restoring
// divider sharing one accumulator/operand/counter set. Operands are reduced
// to magnitudes on load; the signed result is formed combinationally from
// the final registers and captured by the top in its FINISH state.
module alu_iter_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [4:0]       op,
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH);

    // hi: product high half / partial remainder; lo: multiplier / quotient
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] opd;
    logic [CNT_W-1:0] count;
    logic             is_high_r;
    logic             neg_res;
`ifdef ALU_DIV_EN
    logic             is_div_r;
    logic             neg_rem;
    logic             div0;
    logic [WIDTH-1:0] a_raw;
    logic [WIDTH:0]   div_r;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
`endif

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               load_div;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod;

    // Operand magnitudes and per-iteration arithmetic for both algorithms
    always_comb begin
        a_mag    = (sign && a[WIDTH-1]) ? -a : a;
        b_mag    = (sign && b[WIDTH-1]) ? -b : b;
`ifdef ALU_DIV_EN
        load_div = (op == OP_DIV) || (op == OP_REM);
        div_r    = {hi, lo[WIDTH-1]};
        div_ge   = (div_r >= {1'b0, opd});
        // Only taken when div_r >= opd, so the difference fits in WIDTH bits
        div_diff = div_r[WIDTH-1:0] - opd;
`else
        load_div = 1'b0;
`endif
        mul_sum  = {1'b0, hi} + {1'b0, (lo[0] ? opd : '0)};
    end

    // Load on accept, then one shift-add or shift-subtract per step strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            hi        <= '0;
            lo        <= '0;
            opd       <= '0;
            count     <= '0;
            is_high_r <= 1'b0;
            neg_res   <= 1'b0;
`ifdef ALU_DIV_EN
            is_div_r  <= 1'b0;
            neg_rem   <= 1'b0;
            div0      <= 1'b0;
            a_raw     <= '0;
`endif
        end else if (load) begin
            hi        <= '0;
            lo        <= load_div ? a_mag : b_mag;
            opd       <= load_div ? b_mag : a_mag;
            count     <= CNT_W'(WIDTH - 1);
            is_high_r <= (op == OP_MULH) || (op == OP_REM);
            neg_res   <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef ALU_DIV_EN
            is_div_r  <= load_div;
            neg_rem   <= sign & a[WIDTH-1];
            div0      <= (b == '0);
            a_raw     <= a;
`endif
        end else if (step) begin
            count <= count - CNT_W'(1);
`ifdef ALU_DIV_EN
            if (is_div_r) begin
                hi <= div_ge ? div_diff : div_r[WIDTH-1:0];
                lo <= {lo[WIDTH-2:0], div_ge};
            end else begin
`else
            begin
`endif
                hi <= mul_sum[WIDTH:1];
                lo <= {mul_sum[0], lo[WIDTH-1:1]};
            end
        end
    end

    // Sign fix-up and result selection from the final magnitudes
    always_comb begin
        prod_mag = {hi, lo};
        prod     = neg_res ? -prod_mag : prod_mag;
        result   = is_high_r ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
`ifdef ALU_DIV_EN
        quot = neg_res ? -lo : lo;
        rem  = neg_rem ? -hi : hi;
        if (is_div_r) begin
            if (div0) begin
                result = is_high_r ? a_raw : '1;
            end else begin
                result = is_high_r ? rem : quot;
            end
        end
`endif
        last = (count == '0);
    end

endmodule

// File: rtl/alu_seq_muldiv.sv
// Sequential ALU for the multi-cycle CPU: single-cycle logic/arith/shift ops
// plus iterative MUL/MULH and, when ALU_DIV_EN is defined, DIV/REM.
//
// Handshake: start is a request sampled on a rising clock edge only while
// busy=0 (IDLE or DONE); the op is accepted on that edge and any start while
// busy=1 is dropped. done is a one-cycle pulse marking Result valid; there is
// no back-pressure, Result simply holds until the next done.
module alu_seq_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [4:0]       ALUConf,
    input  logic             Sign,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output alu_state_t       dbg_state
);

    alu_state_t         state;
    logic [WIDTH-1:0]   single_res;
    logic [SHAMT_W-1:0] shamt;
    logic               lt;
    logic               accept;
    logic               core_load;
    logic               core_step;
    logic               core_last;
    logic [WIDTH-1:0]   core_res;

    // Single-cycle result mux; unlisted codes (and disabled DIV/REM) give 0
    always_comb begin
        shamt = In1[SHAMT_W-1:0];
        lt    = Sign ? ($signed(In1) < $signed(In2)) : (In1 < In2);
        case (ALUConf)
            OP_ADD:  single_res = In1 + In2;
            OP_OR:   single_res = In1 | In2;
            OP_AND:  single_res = In1 & In2;
            OP_SUB:  single_res = In1 - In2;
            OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, lt};
            OP_NOR:  single_res = ~(In1 | In2);
            OP_XOR:  single_res = In1 ^ In2;
            OP_SRL:  single_res = In2 >> shamt;
            OP_SRA:  single_res = $signed(In2) >>> shamt;
            OP_SLL:  single_res = In2 << shamt;
            OP_ANDN: single_res = In1 & ~In2;
            default: single_res = '0;
        endcase
    end

    // Core strobes: operands latched on the accepting edge, stepping in SETUP/ITER
    always_comb begin
        accept    = start && !busy;
        core_load = accept && is_iter_op(ALUConf);
        core_step = (state == ST_SETUP) || (state == ST_ITER);
    end

    alu_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .reset  (reset),
        .load   (core_load),
        .step   (core_step),
        .op     (ALUConf),
        .sign   (Sign),
        .a      (In1),
        .b      (In2),
        .last   (core_last),
        .result (core_res)
    );

    // Control FSM with registered busy/done/Result. SETUP performs the first
    // of the WIDTH iterations so that done lands WIDTH+2 cycles after start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            Result <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                    if (start) begin
                        if (is_iter_op(ALUConf)) begin
                            state <= ST_SETUP;
                            busy  <= 1'b1;
                        end else begin
                            state  <= ST_DONE;
                            done   <= 1'b1;
                            Result <= single_res;
                        end
                    end
                end
                ST_SETUP: begin
                    state <= ST_ITER;
                end
                ST_ITER: begin
                    if (core_last) begin
                        state <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    Result <= core_res;
                    state  <= ST_DONE;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign Zero      = (Result == '0);
    assign dbg_state = state;

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Self-checking bench for alu_seq_muldiv (WIDTH=32): behavioural model with
// an expected-result queue, randomized stimulus and a few directed cases.
module tb_alu_seq_muldiv;

    localparam int W       = 32;
    localparam int ITER_LAT = W + 2;

    localparam logic [4:0] C_ADD  = 5'b00000;
    localparam logic [4:0] C_OR   = 5'b00001;
    localparam logic [4:0] C_AND  = 5'b00010;
    localparam logic [4:0] C_SUB  = 5'b00110;
    localparam logic [4:0] C_SLT  = 5'b00111;
    localparam logic [4:0] C_MUL  = 5'b01000;
    localparam logic [4:0] C_MULH = 5'b01001;
    localparam logic [4:0] C_DIV  = 5'b01010;
    localparam logic [4:0] C_REM  = 5'b01011;
    localparam logic [4:0] C_NOR  = 5'b01100;
    localparam logic [4:0] C_XOR  = 5'b01101;
    localparam logic [4:0] C_SRL  = 5'b10000;
    localparam logic [4:0] C_SRA  = 5'b11000;
    localparam logic [4:0] C_SLL  = 5'b11001;
    localparam logic [4:0] C_ANDN = 5'b11111;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [4:0]   ALUConf = '0;
    logic         Sign = 1'b0;
    logic [W-1:0] In1 = '0;
    logic [W-1:0] In2 = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] Result;
    logic         Zero;
    alu_pkg::alu_state_t dbg_state;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    logic [W-1:0] exp_q[$];
    int           due_q[$];
    int           issue_q[$];
    bit           iter_q[$];
    logic [W-1:0] exp_res = '0;
    bit           exp_done;
    bit           exp_busy;

    logic [4:0] op_tab[17] = '{C_ADD, C_OR, C_AND, C_SUB, C_SLT, C_NOR, C_XOR, C_SRL,
                               C_SRA, C_SLL, C_ANDN, C_MUL, C_MULH, C_DIV, C_REM,
                               5'b00011, 5'b10100};

    alu_seq_muldiv #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .ALUConf   (ALUConf),
        .Sign      (Sign),
        .In1       (In1),
        .In2       (In2),
        .busy      (busy),
        .done      (done),
        .Result    (Result),
        .Zero      (Zero),
        .dbg_state (dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
        n_checks++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, want);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit model_iter(input logic [4:0] op);
`ifdef ALU_DIV_EN
        return (op == C_MUL) || (op == C_MULH) || (op == C_DIV) || (op == C_REM);
`else
        return (op == C_MUL) || (op == C_MULH);
`endif
    endfunction

    function automatic logic [W-1:0] model(input logic [4:0] op, input logic s,
                                           input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] p;
        logic [4:0]  sh;
        int          sa;
        int          sb;
        sh = a[4:0];
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            C_ADD:  return a + b;
            C_OR:   return a | b;
            C_AND:  return a & b;
            C_SUB:  return a - b;
            C_SLT:  return (s ? (sa < sb) : (a < b)) ? 32'd1 : 32'd0;
            C_NOR:  return ~(a | b);
            C_XOR:  return a ^ b;
            C_SRL:  return b >> sh;
            C_SRA:  return 32'($signed(b) >>> sh);
            C_SLL:  return b << sh;
            C_ANDN: return a & ~b;
            C_MUL, C_MULH: begin
                if (s) p = 64'(longint'(sa) * longint'(sb));
                else   p = {32'b0, a} * {32'b0, b};
                return (op == C_MUL) ? p[31:0] : p[63:32];
            end
`ifdef ALU_DIV_EN
            C_DIV, C_REM: begin
                if (b == 0) return (op == C_DIV) ? 32'hFFFF_FFFF : a;
                if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return (op == C_DIV) ? 32'h8000_0000 : 32'h0;
                if (s) return (op == C_DIV) ? 32'(sa / sb) : 32'(sa % sb);
                return (op == C_DIV) ? a / b : a % b;
            end
`endif
            default: return '0;
        endcase
    endfunction

    // ---------------- driver ----------------
    // Drive one cycle of inputs; a start is recorded only when the model says
    // the ALU is free (no pending op due after this cycle).
    task automatic drive(input bit s, input logic [4:0] op, input logic sg,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        bit it;
        start = s; ALUConf = op; Sign = sg; In1 = a; In2 = b;
        if (s && !(due_q.size() > 0 && due_q[$] > cyc)) begin
            it = model_iter(op);
            exp_q.push_back(model(op, sg, a, b));
            due_q.push_back(cyc + (it ? ITER_LAT : 1));
            issue_q.push_back(cyc);
            iter_q.push_back(it);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, ALUConf, Sign, In1, In2);
    endtask

    task automatic clear_model();
        exp_q.delete(); due_q.delete(); issue_q.delete(); iter_q.delete();
        exp_res = '0;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < bound) begin
            idle(1);
            n++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_err++;
            $display("FAIL drain_timeout at cycle %0d: got %0d pending expected 0", cyc, exp_q.size());
            clear_model();
        end
    endtask

    task automatic run_op(input logic [4:0] op, input logic sg,
                          input logic [W-1:0] a, input logic [W-1:0] b);
        drive(1'b1, op, sg, a, b);
        start = 1'b0;
        wait_idle(ITER_LAT + 10);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        start = 1'b0;
        clear_model();
        idle(n);
        reset = 1'b0;
    endtask

    function automatic logic [W-1:0] rand_opnd();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 15));
            4: return 32'(0 - $urandom_range(1, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        if (!reset) begin
            exp_done = (exp_q.size() > 0) && (due_q[0] == cyc);
            exp_busy = (exp_q.size() > 0) && iter_q[0] && (issue_q[0] < cyc) && (cyc < due_q[0]);
            chk("done", 32'(done), 32'(exp_done));
            chk("busy", 32'(busy), 32'(exp_busy));
            if (exp_done) begin
                exp_res = exp_q.pop_front();
                void'(due_q.pop_front());
                void'(issue_q.pop_front());
                void'(iter_q.pop_front());
            end
            chk("Result", Result, exp_res);
            chk("Zero", 32'(Zero), 32'(exp_res == '0));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // Pin the model with hand-computed values
        chk("pin_add", model(C_ADD, 1'b0, 32'd7, 32'd5), 32'd12);
        chk("pin_sub", model(C_SUB, 1'b0, 32'd5, 32'd5), 32'd0);
        chk("pin_mul", model(C_MUL, 1'b1, 32'hFFFF_FFFD, 32'd7), 32'hFFFF_FFEB);
        chk("pin_mulh", model(C_MULH, 1'b1, 32'hFFFF_FFFD, 32'd7), 32'hFFFF_FFFF);
        chk("pin_mulh_u", model(C_MULH, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
        chk("pin_sra", model(C_SRA, 1'b0, 32'd4, 32'h8000_0000), 32'hF800_0000);
        chk("pin_slt_s", model(C_SLT, 1'b1, 32'hFFFF_FFFF, 32'd1), 32'd1);
        chk("pin_slt_u", model(C_SLT, 1'b0, 32'hFFFF_FFFF, 32'd1), 32'd0);
`ifdef ALU_DIV_EN
        chk("pin_div_s", model(C_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
        chk("pin_rem_s", model(C_REM, 1'b1, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
        chk("pin_div0", model(C_DIV, 1'b0, 32'd9, 32'd0), 32'hFFFF_FFFF);
        chk("pin_rem0", model(C_REM, 1'b0, 32'd9, 32'd0), 32'd9);
        chk("pin_div_ovf", model(C_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
        chk("pin_rem_ovf", model(C_REM, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF), 32'd0);
`else
        chk("pin_div_off", model(C_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2), 32'd0);
`endif

        // Reset, then directed cases through the DUT
        idle(3);
        reset = 1'b0;
        idle(2);
        run_op(C_ADD, 1'b0, 32'd7, 32'd5);
        run_op(C_SUB, 1'b0, 32'd5, 32'd5);
        run_op(C_MUL, 1'b1, 32'hFFFF_FFFD, 32'd7);
        run_op(C_MULH, 1'b1, 32'hFFFF_FFFD, 32'd7);
        run_op(C_SRA, 1'b0, 32'd4, 32'h8000_0000);
        run_op(C_SLT, 1'b1, 32'hFFFF_FFFF, 32'd1);
        run_op(C_SLT, 1'b0, 32'hFFFF_FFFF, 32'd1);
        run_op(C_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2);
        run_op(C_REM, 1'b1, 32'hFFFF_FFF9, 32'd2);
        run_op(C_DIV, 1'b0, 32'd9, 32'd0);
        run_op(C_REM, 1'b0, 32'd9, 32'd0);
        run_op(C_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(C_REM, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(5'b00011, 1'b0, 32'd3, 32'd4);

        // Back-to-back single-cycle ops
        drive(1'b1, C_ADD, 1'b0, 32'd1, 32'd2);
        drive(1'b1, C_XOR, 1'b0, 32'hF0F0_F0F0, 32'hFFFF_0000);
        drive(1'b1, C_SLL, 1'b0, 32'd31, 32'd1);
        start = 1'b0;
        wait_idle(10);

        // start while a MUL is in flight is ignored
        drive(1'b1, C_MUL, 1'b1, 32'hFFFF_FFFD, 32'd7);
        idle(3);
        drive(1'b1, C_ADD, 1'b0, 32'd7, 32'd5);
        start = 1'b0;
        wait_idle(ITER_LAT + 10);

        // Reset in the middle of a MUL: no done afterwards, Result cleared
        drive(1'b1, C_MUL, 1'b0, 32'd123, 32'd456);
        start = 1'b0;
        idle(9);
        do_reset(1);
        idle(ITER_LAT + 5);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 1) == 1)
                drive(1'b1, op_tab[$urandom_range(0, 16)], 1'($urandom_range(0, 1)),
                      rand_opnd(), rand_opnd());
            else
                drive(1'b0, op_tab[$urandom_range(0, 16)], 1'($urandom_range(0, 1)),
                      rand_opnd(), rand_opnd());
        end
        start = 1'b0;
        wait_idle(ITER_LAT + 10);
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
